serial_uart_bridge: RTL

SERIAL_UART_BRIDGE -- requirements
Module: serial_uart_bridge

---
 rtl/serial_uart_bridge_pkg.sv | 22 ++
 rtl/serial_uart_bridge_fifo.sv | 61 ++++++
 rtl/serial_uart_bridge.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_uart_bridge_pkg.sv
// Shared constants and FSM state encodings for the processor <-> UART byte bridge.
package serial_uart_bridge_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BIT_IDX_W = 3;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/serial_uart_bridge_fifo.sv
// Show-ahead byte FIFO; head reads as 0x00 while empty. Push is accepted when full if a pop lands in the same cycle.
module byte_fifo
    import serial_uart_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push_c;
    logic              do_pop_c;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;
    assign do_pop_c  = pop && !empty;
    assign do_push_c = push && (!full || do_pop_c);
    assign head_data = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (do_push_c) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/serial_uart_bridge.sv
// Processor MMIO byte port bridged to an 8N1 UART, with a byte FIFO in each direction.
module serial_uart_bridge
    import serial_uart_bridge_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [BYTE_W-1:0] proc_data_in,
    input  logic              proc_wren_in,
    input  logic              proc_rden_in,
    output logic [BYTE_W-1:0] proc_data_out,
    output logic              proc_valid_out,
    output logic              proc_ready_out,
    input  logic              uart_rx_in,
    output logic              uart_tx_out,
    output logic              rx_frame_err_out,
    output logic              rx_overflow_out
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0]    BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0]    HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_DATA = BIT_IDX_W'(DATA_BITS - 1);

    logic [BYTE_W-1:0] tx_head, rx_head;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [CNT_W-1:0]  tx_count, rx_count;
    logic              tx_push_c, tx_pop_c, rx_push_c, rx_pop_c;

    tx_state_t             tx_state_q, tx_state_d;
    logic [BAUD_W-1:0]     tx_baud_q, tx_baud_d;
    logic [BIT_IDX_W-1:0]  tx_bit_q, tx_bit_d;
    logic [BYTE_W-1:0]     tx_shift_q, tx_shift_d;
    logic                  tx_line_q, tx_line_d;

    rx_state_t             rx_state_q, rx_state_d;
    logic [BAUD_W-1:0]     rx_baud_q, rx_baud_d;
    logic [BIT_IDX_W-1:0]  rx_bit_q, rx_bit_d;
    logic [BYTE_W-1:0]     rx_shift_q, rx_shift_d;
    logic [1:0]            rx_sync_q;
    logic                  rx_line;
    logic                  rx_frame_err_q, rx_frame_err_d;
    logic                  rx_overflow_q, rx_overflow_d;

    assign tx_push_c        = proc_wren_in && !tx_full;
    assign rx_pop_c         = proc_rden_in && !rx_empty;
    assign rx_line          = rx_sync_q[1];
    assign proc_ready_out   = (tx_count != CNT_W'(FIFO_DEPTH));
    assign proc_valid_out   = (rx_count != '0);
    assign proc_data_out    = rx_head;
    assign uart_tx_out      = tx_line_q;
    assign rx_frame_err_out = rx_frame_err_q;
    assign rx_overflow_out  = rx_overflow_q;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_push_c),
        .push_data (proc_data_in),
        .pop       (tx_pop_c),
        .head_data (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push_c),
        .push_data (rx_shift_q),
        .pop       (rx_pop_c),
        .head_data (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // TX: the line register is loaded with the next bit value on each bit boundary.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        tx_pop_c   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_line_d = 1'b1;
                if (!tx_empty) begin
                    tx_pop_c   = 1'b1;
                    tx_shift_d = tx_head;
                    tx_baud_d  = '0;
                    tx_line_d  = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_baud_q == BIT_LAST) begin
                    tx_baud_d  = '0;
                    tx_bit_d   = '0;
                    tx_line_d  = tx_shift_q[0];
                    tx_state_d = TX_DATA;
                end else begin
                    tx_baud_d = tx_baud_q + BAUD_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_baud_q == BIT_LAST) begin
                    tx_baud_d  = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == LAST_DATA) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d  = tx_bit_q + BIT_IDX_W'(1);
                        tx_line_d = tx_shift_q[1];
                    end
                end else begin
                    tx_baud_d = tx_baud_q + BAUD_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_baud_q == BIT_LAST) begin
                    tx_baud_d  = '0;
                    tx_state_d = TX_IDLE;
                    // Chain straight into the next frame so queued bytes leave no idle gap.
                    if (!tx_empty) begin
                        tx_pop_c   = 1'b1;
                        tx_shift_d = tx_head;
                        tx_line_d  = 1'b0;
                        tx_state_d = TX_START;
                    end
                end else begin
                    tx_baud_d = tx_baud_q + BAUD_W'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state_q     <= RX_IDLE;
            rx_baud_q      <= '0;
            rx_bit_q       <= '0;
            rx_shift_q     <= '0;
            rx_sync_q      <= 2'b11;
            rx_frame_err_q <= 1'b0;
            rx_overflow_q  <= 1'b0;
        end else begin
            rx_state_q     <= rx_state_d;
            rx_baud_q      <= rx_baud_d;
            rx_bit_q       <= rx_bit_d;
            rx_shift_q     <= rx_shift_d;
            rx_sync_q      <= {rx_sync_q[0], uart_rx_in};
            rx_frame_err_q <= rx_frame_err_d;
            rx_overflow_q  <= rx_overflow_d;
        end
    end

    // RX: half-bit wait in START re-centres all later samples mid-bit.
    always_comb begin
        rx_state_d     = rx_state_q;
        rx_baud_d      = rx_baud_q;
        rx_bit_d       = rx_bit_q;
        rx_shift_d     = rx_shift_q;
        rx_frame_err_d = 1'b0;
        rx_overflow_d  = 1'b0;
        rx_push_c      = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_line) begin
                    rx_baud_d  = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_baud_q == HALF_LAST) begin
                    rx_baud_d  = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_line ? RX_IDLE : RX_DATA;
                end else begin
                    rx_baud_d = rx_baud_q + BAUD_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_baud_q == BIT_LAST) begin
                    rx_baud_d  = '0;
                    rx_shift_d = {rx_line, rx_shift_q[BYTE_W-1:1]};
                    if (rx_bit_q == LAST_DATA) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + BIT_IDX_W'(1);
                    end
                end else begin
                    rx_baud_d = rx_baud_q + BAUD_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_baud_q == BIT_LAST) begin
                    rx_baud_d  = '0;
                    rx_state_d = RX_IDLE;
                    if (!rx_line) begin
                        rx_frame_err_d = 1'b1;
                    end else if (rx_full) begin
                        rx_overflow_d = 1'b1;
                    end else begin
                        rx_push_c = 1'b1;
                    end
                end else begin
                    rx_baud_d = rx_baud_q + BAUD_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

endmodule
